sap_ctrl_seq: RTL

//   Fetch/decode/execute sequencer for the 16-bit SAP core.
//   - Drives every datapath load/enable strobe.
//   - Paces instruction fetch into the instruction register: pulses ir_write while RAM drives the bus.
//   - Decodes ir_out[15:12] once latched; ir_out[11:0] is the address/immediate field.
//   - Sits beside the shared bus; owns bus-source selection so exactly one driver is enabled per cycle.

---
 rtl/sap_ctrl_seq.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/sap_ctrl_seq.sv
// Fetch/decode/execute sequencer for the 16-bit SAP core; owns every datapath strobe and bus-source select.
// Optional build macro SAP_SINGLE_STEP_EN adds a step_req input that gates each instruction start in T0.
module sap_ctrl_seq #(
    parameter int DATA_W = 16,
    parameter int OPC_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ir_out,
    input  logic              carry_flag,
    input  logic              zero_flag,
`ifdef SAP_SINGLE_STEP_EN
    input  logic              step_req,
`endif
    output logic              pc_out,
    output logic              pc_inc,
    output logic              pc_load,
    output logic              mar_write,
    output logic              ram_out,
    output logic              ram_write,
    output logic              ir_write,
    output logic              ir_addr_out,
    output logic              a_write,
    output logic              a_out,
    output logic              b_write,
    output logic              alu_out,
    output logic              alu_sub,
    output logic              flags_write,
    output logic              out_write,
    output logic              halted,
    output logic [2:0]        t_step
);

    typedef enum logic [2:0] {
        ST_T0   = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_HALT = 3'd7
    } state_t;

    localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_STA = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_JC  = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(14);
    localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(15);

    state_t           state_reg;
    state_t           state_next;
    logic [OPC_W-1:0] opcode;
    logic             go;
    logic             unused_ir_bits;

    assign opcode         = ir_out[DATA_W-1 -: OPC_W];
    // The address/immediate field travels to the bus through the IR itself, not through this block.
    assign unused_ir_bits = ^ir_out[DATA_W-OPC_W-1:0];

`ifdef SAP_SINGLE_STEP_EN
    assign go = step_req;
`else
    assign go = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_T0;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_out      = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        mar_write   = 1'b0;
        ram_out     = 1'b0;
        ram_write   = 1'b0;
        ir_write    = 1'b0;
        ir_addr_out = 1'b0;
        a_write     = 1'b0;
        a_out       = 1'b0;
        b_write     = 1'b0;
        alu_out     = 1'b0;
        alu_sub     = 1'b0;
        flags_write = 1'b0;
        out_write   = 1'b0;
        halted      = (state_reg == ST_HALT);
        t_step      = state_reg;

        // Reset silences every strobe combinationally so an abort takes effect before the next edge.
        if (!rst) begin
            unique case (state_reg)
                ST_T0: begin
                    if (go) begin
                        pc_out     = 1'b1;
                        mar_write  = 1'b1;
                        state_next = ST_T1;
                    end
                end
                ST_T1: begin
                    ram_out    = 1'b1;
                    ir_write   = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = ST_T2;
                end
                ST_T2: begin
                    state_next = ST_T0;
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ir_addr_out = 1'b1;
                            mar_write   = 1'b1;
                            state_next  = ST_T3;
                        end
                        OP_LDI: begin
                            ir_addr_out = 1'b1;
                            a_write     = 1'b1;
                        end
                        OP_JMP: begin
                            ir_addr_out = 1'b1;
                            pc_load     = 1'b1;
                        end
                        OP_JC: begin
                            ir_addr_out = carry_flag;
                            pc_load     = carry_flag;
                        end
                        OP_JZ: begin
                            ir_addr_out = zero_flag;
                            pc_load     = zero_flag;
                        end
                        OP_OUT: begin
                            a_out     = 1'b1;
                            out_write = 1'b1;
                        end
                        OP_HLT: state_next = ST_HALT;
                        default: ;
                    endcase
                end
                ST_T3: begin
                    state_next = ST_T0;
                    case (opcode)
                        OP_LDA: begin
                            ram_out = 1'b1;
                            a_write = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_out    = 1'b1;
                            b_write    = 1'b1;
                            state_next = ST_T4;
                        end
                        OP_STA: begin
                            a_out     = 1'b1;
                            ram_write = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_T4: begin
                    alu_out     = 1'b1;
                    a_write     = 1'b1;
                    flags_write = 1'b1;
                    alu_sub     = (opcode == OP_SUB);
                    state_next  = ST_T0;
                end
                ST_HALT: state_next = ST_HALT;
                default: state_next = ST_T0;
            endcase
        end
    end

endmodule
